// File: rtl/dedup_pkg.sv
// Shared definitions for the RemoveDuplicates result path: streamer FSM states,
// default array geometry and the index-width helper.
package dedup_pkg;

    localparam int unsigned DEF_NUM_ELEMENTS = 10;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_K_W          = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dedup_state_t;

    // Width of an element index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dedup_result_streamer_if.sv
// Valid/ready element stream produced by dedup_result_streamer.
interface dedup_result_streamer_if
    import dedup_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = idx_w(DEF_NUM_ELEMENTS)
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/dedup_order_check.sv
// Tracks the previously emitted element and raises a sticky flag when the
// stream is not strictly ascending.
module dedup_order_check
    import dedup_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic [DATA_W-1:0] data,
    output logic              err_order
);
    logic [DATA_W-1:0] prev_q;
    logic              have_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            err_order   <= 1'b0;
        end else if (clr) begin
            have_prev_q <= 1'b0;
            err_order   <= 1'b0;
        end else if (upd) begin
            // First beat of a stream has nothing to compare against.
            if (have_prev_q && (data <= prev_q)) begin
                err_order <= 1'b1;
            end
            prev_q      <= data;
            have_prev_q <= 1'b1;
        end
    end

endmodule

// File: rtl/dedup_result_streamer.sv
// Snapshots the RemoveDuplicates result (array + count k) on start and drains
// k elements onto a valid/ready stream, flagging bad k and non-ascending data.
module dedup_result_streamer
    import dedup_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned K_W          = DEF_K_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_ELEMENTS*DATA_W-1:0] nums_in,
    input  logic [K_W-1:0]                 k_in,
    output logic                           busy,
    dedup_result_streamer_if.master        strm,
    output logic                           done,
    output logic                           err_k,
    output logic                           err_order
);
    localparam int unsigned IDX_W = idx_w(NUM_ELEMENTS);
    localparam int unsigned KC_W  = $clog2(NUM_ELEMENTS + 1);

    dedup_state_t      state_q;
    logic [DATA_W-1:0] nums_arr [NUM_ELEMENTS];
    logic [DATA_W-1:0] snap_q   [NUM_ELEMENTS];

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_index_q;
    logic              out_last_q;
    logic [IDX_W-1:0]  last_idx_q;

    logic              k_over;
    logic [KC_W-1:0]   k_eff;
    logic              accept_start;
    logic              xfer;
    logic [IDX_W-1:0]  next_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            nums_arr[i] = nums_in[i*DATA_W +: DATA_W];
        end
    end

    // k is judged at full input width before being clamped to the array depth.
    assign k_over       = k_in > K_W'(NUM_ELEMENTS);
    assign k_eff        = k_over ? KC_W'(NUM_ELEMENTS) : KC_W'(k_in);
    assign accept_start = (state_q == IDLE) && start;
    assign xfer         = out_valid_q && strm.out_ready;
    assign next_idx     = out_index_q + 1'b1;

    always_ff @(posedge clk) begin
        if (accept_start) begin
            snap_q <= nums_arr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_k       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            last_idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        err_k       <= k_over;
                        out_index_q <= '0;
                        last_idx_q  <= IDX_W'(k_eff - KC_W'(1));
                        if (k_eff == '0) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            // First beat comes straight from the inputs; the snapshot
                            // is written on this same edge.
                            state_q     <= STREAM;
                            out_valid_q <= 1'b1;
                            out_data_q  <= nums_arr[0];
                            out_last_q  <= (k_eff == KC_W'(1));
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (out_last_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            out_index_q <= next_idx;
                            out_data_q  <= snap_q[next_idx];
                            out_last_q  <= (next_idx == last_idx_q);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_index = out_index_q;
    assign strm.out_last  = out_last_q;

    dedup_order_check #(
        .DATA_W(DATA_W)
    ) u_order_check (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept_start),
        .upd       (xfer),
        .data      (out_data_q),
        .err_order (err_order)
    );

endmodule
